inst_queue: RTL and testbench

Parametrised multi-slot instruction queue between the fetch stage (pc/icache/bpu) and decode. Accepts up to FETCH_W fetched instructions per cycle with per-slot valid (non-contiguous allowed), compacts them into a circular buffer, and presents up to ISSUE_W oldest entries per cycle to decode with a prefix-ready handshake. Carries PC, exception tag and branch-prediction bit per entry. Supports flush and pause, and raises back-pressure to the pc stage.

---
 rtl/inst_queue_pkg.sv | 27 ++
 rtl/inst_queue_compact.sv | 25 ++
 rtl/inst_queue.sv | 131 +++++++++++++
 tb/tb_inst_queue.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/inst_queue_pkg.sv
// Shared definitions for the fetch-to-decode instruction queue: exception
// cause codes common with the pc stage and the packed entry layout.
package inst_queue_pkg;

  localparam int unsigned ECODE_W_DEFAULT = 7;

  // Fetch-side exception causes raised by the pc stage.
  typedef enum logic [ECODE_W_DEFAULT-1:0] {
    ECODE_INT  = 7'h00,
    ECODE_ADEF = 7'h08,
    ECODE_SYS  = 7'h0b,
    ECODE_BRK  = 7'h0c,
    ECODE_INE  = 7'h0d
  } ecode_e;

  // Packed entry layout, LSB first: pred_taken, is_exception, cause, inst, pc.
  localparam int unsigned PRED_LSB  = 0;
  localparam int unsigned EXC_LSB   = 1;
  localparam int unsigned CAUSE_LSB = 2;

  function automatic int unsigned entry_width(input int unsigned pc_w,
                                              input int unsigned inst_w,
                                              input int unsigned ecode_w);
    return pc_w + inst_w + ecode_w + 2;
  endfunction

endpackage

// File: rtl/inst_queue_compact.sv
// Popcount of the fetch valid mask plus the compacted write offset of each
// slot (number of valid slots below it).
module inst_queue_compact #(
  parameter int unsigned FETCH_W = 2,
  parameter int unsigned OFF_W   = $clog2(FETCH_W + 1)
) (
  input  logic [FETCH_W-1:0]            valid,
  output logic [OFF_W-1:0]              n_valid,
  output logic [FETCH_W-1:0][OFF_W-1:0] offset
);

  logic [OFF_W-1:0] acc;

  // Running prefix count: each slot's offset is the count of valid slots before it.
  always_comb begin
    acc    = '0;
    offset = '0;
    for (int unsigned i = 0; i < FETCH_W; i++) begin
      offset[i] = acc;
      acc       = acc + OFF_W'(valid[i]);
    end
    n_valid = acc;
  end

endmodule

// File: rtl/inst_queue.sv
// Multi-slot instruction queue between fetch and decode. Compacts up to
// FETCH_W valid fetch slots into a circular buffer and presents up to
// ISSUE_W oldest entries to decode with a prefix-ready handshake.
module inst_queue
  import inst_queue_pkg::*;
#(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned FETCH_W = 2,
  parameter int unsigned ISSUE_W = 2,
  parameter int unsigned PC_W    = 32,
  parameter int unsigned INST_W  = 32,
  parameter int unsigned ECODE_W = ECODE_W_DEFAULT
) (
  input  logic                         cpu_clk,
  input  logic                         cpu_rst,
  input  logic                         flush,
  input  logic                         pause,
  input  logic [FETCH_W-1:0]           in_valid,
  input  logic [FETCH_W*PC_W-1:0]      in_pc,
  input  logic [FETCH_W*INST_W-1:0]    in_inst,
  input  logic [FETCH_W-1:0]           in_is_exception,
  input  logic [FETCH_W*ECODE_W-1:0]   in_exception_cause,
  input  logic [FETCH_W-1:0]           in_pred_taken,
  output logic                         buffer_full,
  output logic [ISSUE_W-1:0]           out_valid,
  output logic [ISSUE_W*PC_W-1:0]      out_pc,
  output logic [ISSUE_W*INST_W-1:0]    out_inst,
  output logic [ISSUE_W-1:0]           out_is_exception,
  output logic [ISSUE_W*ECODE_W-1:0]   out_exception_cause,
  output logic [ISSUE_W-1:0]           out_pred_taken,
  input  logic [ISSUE_W-1:0]           out_ready,
  output logic [$clog2(DEPTH):0]       count
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam int unsigned PW       = AW + 1;
  localparam int unsigned OFF_W    = $clog2(FETCH_W + 1);
  localparam int unsigned EW       = entry_width(PC_W, INST_W, ECODE_W);
  localparam int unsigned INST_LSB = CAUSE_LSB + ECODE_W;
  localparam int unsigned PC_LSB   = INST_LSB + INST_W;

  logic [EW-1:0]                  mem [DEPTH];
  logic [PW-1:0]                  wr_ptr, rd_ptr, occ, n_deq;
  logic [OFF_W-1:0]               n_enq;
  logic [FETCH_W-1:0][OFF_W-1:0]  slot_off;
  logic [FETCH_W-1:0][AW-1:0]     wr_idx;
  logic [ISSUE_W-1:0][AW-1:0]     rd_idx;
  logic                           accept;

  inst_queue_compact #(
    .FETCH_W (FETCH_W),
    .OFF_W   (OFF_W)
  ) u_compact (
    .valid   (in_valid),
    .n_valid (n_enq),
    .offset  (slot_off)
  );

  assign occ         = wr_ptr - rd_ptr;
  assign count       = occ;
  assign buffer_full = occ > PW'(DEPTH - FETCH_W);
  assign accept      = (|in_valid) & ~buffer_full & ~pause & ~flush;

  // Compacted write addresses: valid slots land on consecutive entries from wr_ptr.
  always_comb begin
    wr_idx = '0;
    for (int unsigned i = 0; i < FETCH_W; i++)
      wr_idx[i] = wr_ptr[AW-1:0] + AW'(slot_off[i]);
  end

  // Entry storage, written only for accepted valid slots (no reset needed).
  always_ff @(posedge cpu_clk) begin
    for (int unsigned i = 0; i < FETCH_W; i++) begin
      if (accept && in_valid[i])
        mem[wr_idx[i]] <= {in_pc[i*PC_W +: PC_W],
                           in_inst[i*INST_W +: INST_W],
                           in_exception_cause[i*ECODE_W +: ECODE_W],
                           in_is_exception[i],
                           in_pred_taken[i]};
    end
  end

  // Present the ISSUE_W oldest entries; pause/flush mask the valids.
  always_comb begin
    rd_idx              = '0;
    out_valid           = '0;
    out_pc              = '0;
    out_inst            = '0;
    out_is_exception    = '0;
    out_exception_cause = '0;
    out_pred_taken      = '0;
    for (int unsigned i = 0; i < ISSUE_W; i++) begin
      rd_idx[i]                                = rd_ptr[AW-1:0] + AW'(i);
      out_valid[i]                             = (occ > PW'(i)) & ~pause & ~flush;
      out_pc[i*PC_W +: PC_W]                   = mem[rd_idx[i]][PC_LSB +: PC_W];
      out_inst[i*INST_W +: INST_W]             = mem[rd_idx[i]][INST_LSB +: INST_W];
      out_exception_cause[i*ECODE_W +: ECODE_W] = mem[rd_idx[i]][CAUSE_LSB +: ECODE_W];
      out_is_exception[i]                      = mem[rd_idx[i]][EXC_LSB];
      out_pred_taken[i]                        = mem[rd_idx[i]][PRED_LSB];
    end
  end

  // Dequeue count is the leading run of accepted slots; ready after a gap is ignored.
  always_comb begin
    logic run;
    run   = 1'b1;
    n_deq = '0;
    for (int unsigned i = 0; i < ISSUE_W; i++) begin
      if (run && out_valid[i] && out_ready[i])
        n_deq = n_deq + PW'(1);
      else
        run = 1'b0;
    end
  end

  // Pointer update; flush wins over enqueue/dequeue, pause already zeroes n_deq.
  always_ff @(posedge cpu_clk or negedge cpu_rst) begin
    if (!cpu_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (accept)
        wr_ptr <= wr_ptr + PW'(n_enq);
      rd_ptr <= rd_ptr + n_deq;
    end
  end

endmodule

// File: tb/tb_inst_queue.sv
// Directed self-checking bench for inst_queue (DEPTH=16, FETCH_W=ISSUE_W=2).
module tb_inst_queue;

  localparam int unsigned DEPTH   = 16;
  localparam int unsigned FETCH_W = 2;
  localparam int unsigned ISSUE_W = 2;
  localparam logic [31:0] IMASK   = 32'hffff_0000;

  logic        cpu_clk = 1'b0;
  logic        cpu_rst = 1'b0;
  logic        flush   = 1'b0;
  logic        pause   = 1'b0;
  logic [1:0]  in_valid = '0;
  logic [63:0] in_pc = '0;
  logic [63:0] in_inst = '0;
  logic [1:0]  in_is_exception = '0;
  logic [13:0] in_exception_cause = '0;
  logic [1:0]  in_pred_taken = '0;
  logic        buffer_full;
  logic [1:0]  out_valid;
  logic [63:0] out_pc;
  logic [63:0] out_inst;
  logic [1:0]  out_is_exception;
  logic [13:0] out_exception_cause;
  logic [1:0]  out_pred_taken;
  logic [1:0]  out_ready = '0;
  logic [4:0]  count;

  int checks   = 0;
  int failures = 0;

  inst_queue #(
    .DEPTH   (DEPTH),
    .FETCH_W (FETCH_W),
    .ISSUE_W (ISSUE_W),
    .PC_W    (32),
    .INST_W  (32),
    .ECODE_W (7)
  ) dut (
    .cpu_clk             (cpu_clk),
    .cpu_rst             (cpu_rst),
    .flush               (flush),
    .pause               (pause),
    .in_valid            (in_valid),
    .in_pc               (in_pc),
    .in_inst             (in_inst),
    .in_is_exception     (in_is_exception),
    .in_exception_cause  (in_exception_cause),
    .in_pred_taken       (in_pred_taken),
    .buffer_full         (buffer_full),
    .out_valid           (out_valid),
    .out_pc              (out_pc),
    .out_inst            (out_inst),
    .out_is_exception    (out_is_exception),
    .out_exception_cause (out_exception_cause),
    .out_pred_taken      (out_pred_taken),
    .out_ready           (out_ready),
    .count               (count)
  );

  always #5 cpu_clk = ~cpu_clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] v, input logic [31:0] pc0, input logic [31:0] pc1);
    in_valid = v;
    in_pc    = {pc1, pc0};
    in_inst  = {pc1 ^ IMASK, pc0 ^ IMASK};
  endtask

  function automatic logic [31:0] fpc(input logic [31:0] base, input int k);
    return base + 32'(4 * k);
  endfunction

  localparam logic [31:0] B1 = 32'h1c00_1000;
  localparam logic [31:0] B2 = 32'h1c00_2000;

  initial begin
    // Reset state
    #2;
    check("rst_count", 64'(count), 64'd0);
    check("rst_full", 64'(buffer_full), 64'd0);
    check("rst_valid", 64'(out_valid), 64'd0);
    tick();
    tick();
    cpu_rst = 1'b1;
    tick();

    // Two-slot enqueue with side fields
    drive(2'b11, 32'h1c00_0000, 32'h1c00_0004);
    in_is_exception    = 2'b10;
    in_exception_cause = {7'h0d, 7'h00};
    in_pred_taken      = 2'b01;
    tick();
    drive(2'b00, '0, '0);
    in_is_exception = '0; in_exception_cause = '0; in_pred_taken = '0;
    check("e2_valid", 64'(out_valid), 64'h3);
    check("e2_pc0", 64'(out_pc[31:0]), 64'h1c00_0000);
    check("e2_pc1", 64'(out_pc[63:32]), 64'h1c00_0004);
    check("e2_inst1", 64'(out_inst[63:32]), 64'(32'h1c00_0004 ^ IMASK));
    check("e2_exc", 64'(out_is_exception), 64'h2);
    check("e2_cause1", 64'(out_exception_cause[13:7]), 64'h0d);
    check("e2_pred", 64'(out_pred_taken), 64'h1);
    check("e2_count", 64'(count), 64'd2);
    out_ready = 2'b11;
    tick();
    out_ready = 2'b00;
    check("deq2_count", 64'(count), 64'd0);
    check("deq2_valid", 64'(out_valid), 64'd0);

    // Compaction: only slot 1 valid
    drive(2'b10, 32'hdead_beef, 32'h1c00_0024);
    tick();
    drive(2'b00, '0, '0);
    check("cmp_valid", 64'(out_valid), 64'h1);
    check("cmp_pc0", 64'(out_pc[31:0]), 64'h1c00_0024);
    check("cmp_count", 64'(count), 64'd1);
    out_ready = 2'b01;
    tick();
    out_ready = 2'b00;
    check("cmp_drain", 64'(count), 64'd0);

    // Fill: rd_ptr=wr_ptr=3, 15 entries occupy 3..15,0,1
    for (int c = 0; c < 7; c++) begin
      drive(2'b11, fpc(B1, 2*c), fpc(B1, 2*c+1));
      tick();
    end
    check("fill14_count", 64'(count), 64'd14);
    check("fill14_full", 64'(buffer_full), 64'd0);
    drive(2'b01, fpc(B1, 14), 32'h0);
    tick();
    check("fill15_count", 64'(count), 64'd15);
    check("fill15_full", 64'(buffer_full), 64'd1);
    for (int c = 0; c < 2; c++) begin
      drive(2'b11, 32'hbad0_0000, 32'hbad0_0004);
      tick();
      check("drop_count", 64'(count), 64'd15);
    end
    drive(2'b00, '0, '0);

    // Non-prefix ready: nothing dequeued
    out_ready = 2'b10;
    tick();
    check("gap_count", 64'(count), 64'd15);
    check("gap_pc0", 64'(out_pc[31:0]), 64'(fpc(B1, 0)));

    // Drain in order across the wrap
    out_ready = 2'b11;
    for (int j = 0; j < 7; j++) begin
      check("drain_pc0", 64'(out_pc[31:0]), 64'(fpc(B1, 2*j)));
      check("drain_pc1", 64'(out_pc[63:32]), 64'(fpc(B1, 2*j+1)));
      check("drain_inst0", 64'(out_inst[31:0]), 64'(fpc(B1, 2*j) ^ IMASK));
      tick();
      check("drain_count", 64'(count), 64'(15 - 2*(j+1)));
    end
    check("last_valid", 64'(out_valid), 64'h1);
    check("last_pc0", 64'(out_pc[31:0]), 64'(fpc(B1, 14)));
    tick();
    out_ready = 2'b00;
    check("empty_count", 64'(count), 64'd0);
    check("empty_valid", 64'(out_valid), 64'd0);

    // Pause with simultaneous enqueue/dequeue
    for (int c = 0; c < 7; c++) begin
      drive(2'b11, fpc(B2, 2*c), fpc(B2, 2*c+1));
      tick();
    end
    check("p_fill_count", 64'(count), 64'd14);
    drive(2'b11, fpc(B2, 14), fpc(B2, 15));
    out_ready = 2'b11;
    pause = 1'b1;
    #1;
    check("p_valid", 64'(out_valid), 64'd0);
    tick();
    check("p_count", 64'(count), 64'd14);
    check("p_pc0", 64'(out_pc[31:0]), 64'(fpc(B2, 0)));
    pause = 1'b0;
    #1;
    check("up_valid", 64'(out_valid), 64'h3);
    tick();
    drive(2'b00, '0, '0);
    out_ready = 2'b00;
    check("up_count", 64'(count), 64'd14);
    check("up_pc0", 64'(out_pc[31:0]), 64'(fpc(B2, 2)));

    // Reach count 9, then flush with concurrent traffic
    out_ready = 2'b01;
    tick();
    out_ready = 2'b11;
    tick();
    tick();
    check("f_pre_count", 64'(count), 64'd9);
    flush = 1'b1;
    drive(2'b11, 32'h1c00_3000, 32'h1c00_3004);
    #1;
    check("f_valid_comb", 64'(out_valid), 64'd0);
    tick();
    flush = 1'b0;
    drive(2'b00, '0, '0);
    out_ready = 2'b00;
    check("f_count", 64'(count), 64'd0);
    check("f_valid", 64'(out_valid), 64'd0);
    check("f_full", 64'(buffer_full), 64'd0);
    tick();
    check("f_count2", 64'(count), 64'd0);

    // Asynchronous reset mid-operation
    drive(2'b11, 32'h1c00_4000, 32'h1c00_4004);
    tick();
    drive(2'b00, '0, '0);
    check("ar_pre_count", 64'(count), 64'd2);
    #2;
    cpu_rst = 1'b0;
    #1;
    check("ar_count", 64'(count), 64'd0);
    check("ar_valid", 64'(out_valid), 64'd0);
    tick();
    cpu_rst = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
